encoder_8to3_seq: RTL and testbench

ENCODER_8TO3_SEQ -- requirements
Module: encoder_8to3_seq

---
 rtl/encoder_pkg.sv | 15 +
 rtl/prio_enc8.sv | 45 ++++
 rtl/encoder_8to3_seq.sv | 112 +++++++++++
 tb/tb_encoder_8to3_seq.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/encoder_pkg.sv
// encoder_pkg -- shared definitions for the sequential 8-to-3 encoder.
//   buf_state_e : state of the one-entry output buffer (EMPTY / FULL)
//   D_W         : width of the request vector
//   CODE_W      : width of the encoded index
package encoder_pkg;

  localparam int D_W    = 8;
  localparam int CODE_W = 3;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } buf_state_e;

endpackage : encoder_pkg

// File: rtl/prio_enc8.sv
// prio_enc8 -- combinational 8-to-3 priority encoder.
//   Parameter PRIORITY_HIGH : 1 = highest set index wins, 0 = lowest wins.
//   d     in  [7:0] request vector
//   code  out [2:0] index of the winning bit (0 when d == 0)
//   zero  out       d has no bit set
//   multi out       d has more than one bit set
module prio_enc8
  import encoder_pkg::*;
#(
  parameter int PRIORITY_HIGH = 1
) (
  input  logic [D_W-1:0]    d,
  output logic [CODE_W-1:0] code,
  output logic              zero,
  output logic              multi
);

  localparam logic [D_W-1:0] ONE = D_W'(1);

  logic found;

  // Ascending scan: for high priority the last set bit seen wins; for low
  // priority the first set bit seen is latched via 'found'.
  always_comb begin
    code  = '0;
    found = 1'b0;
    for (int i = 0; i < D_W; i++) begin
      if (d[i]) begin
        if (PRIORITY_HIGH != 0) begin
          code = CODE_W'(i);
        end else if (!found) begin
          code  = CODE_W'(i);
          found = 1'b1;
        end
      end
    end
  end

  // Clearing the lowest set bit leaves something only if two or more were set.
  always_comb begin
    zero  = (d == '0);
    multi = ((d & (d - ONE)) != '0);
  end

endmodule : prio_enc8

// File: rtl/encoder_8to3_seq.sv
// encoder_8to3_seq -- registered 8-to-3 priority encoder with a one-entry
// valid/ready output buffer and a saturating accepted-word counter.
//   Parameters: PRIORITY_HIGH (1 = highest index wins), CNT_W (counter width)
//   clk       in        clock, rising edge
//   rst       in        synchronous active-high reset
//   d         in  [7:0] request vector
//   in_valid  in        d is valid
//   in_ready  out       block can take d this cycle
//   code      out [2:0] encoded index of the held result
//   zero      out       held result came from an all-zero word
//   multi     out       held result came from a word with >1 bit set
//   out_valid out       code/zero/multi hold a result
//   out_ready in        consumer takes the result this cycle
//   acc_cnt   out       saturating count of accepted words
//
// Handshake: a word transfers on a rising edge where valid and ready are both
// 1. in_ready depends combinationally on out_ready when the buffer is FULL,
// so a drain and a new accept can share one edge with no bubble.
module encoder_8to3_seq
  import encoder_pkg::*;
#(
  parameter int PRIORITY_HIGH = 1,
  parameter int CNT_W         = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [D_W-1:0]    d,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [CODE_W-1:0] code,
  output logic              zero,
  output logic              multi,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  acc_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  buf_state_e          state;
  buf_state_e          state_next;
  logic                accept;
  logic [CODE_W-1:0]   enc_code;
  logic                enc_zero;
  logic                enc_multi;

  prio_enc8 #(
    .PRIORITY_HIGH(PRIORITY_HIGH)
  ) u_prio (
    .d     (d),
    .code  (enc_code),
    .zero  (enc_zero),
    .multi (enc_multi)
  );

  assign accept = in_valid & in_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      ST_EMPTY: if (accept) state_next = ST_FULL;
      ST_FULL: begin
        if (accept) begin
          state_next = ST_FULL;
        end else if (out_ready) begin
          state_next = ST_EMPTY;
        end
      end
      default: state_next = ST_EMPTY;
    endcase
  end

  // Output logic
  always_comb begin
    out_valid = (state == ST_FULL);
    in_ready  = (state == ST_EMPTY) | out_ready;
  end

  // Result register: loads only on accept, so a drain leaves the old values.
  always_ff @(posedge clk) begin
    if (rst) begin
      code  <= '0;
      zero  <= 1'b0;
      multi <= 1'b0;
    end else if (accept) begin
      code  <= enc_code;
      zero  <= enc_zero;
      multi <= enc_multi;
    end
  end

  // Accepted-word counter, sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_cnt <= '0;
    end else if (accept && (acc_cnt != CNT_MAX)) begin
      acc_cnt <= acc_cnt + CNT_ONE;
    end
  end

endmodule : encoder_8to3_seq

// File: tb/tb_encoder_8to3_seq.sv
// tb_encoder_8to3_seq -- self-checking bench for encoder_8to3_seq.
// Three instances share one stimulus stream: high priority / 8-bit counter,
// low priority / 8-bit counter, and high priority / 2-bit counter.
module tb_encoder_8to3_seq;

  logic       clk;
  logic       rst;
  logic [7:0] d;
  logic       in_valid;
  logic       out_ready;

  logic       in_ready_hi, in_ready_lo, in_ready_sat;
  logic [2:0] code_hi, code_lo, code_sat;
  logic       zero_hi, zero_lo, zero_sat;
  logic       multi_hi, multi_lo, multi_sat;
  logic       out_valid_hi, out_valid_lo, out_valid_sat;
  logic [7:0] cnt_hi, cnt_lo;
  logic [1:0] cnt_sat;

  int n_cmp;
  int n_bad;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  encoder_8to3_seq #(.PRIORITY_HIGH(1), .CNT_W(8)) u_hi (
    .clk(clk), .rst(rst), .d(d), .in_valid(in_valid), .in_ready(in_ready_hi),
    .code(code_hi), .zero(zero_hi), .multi(multi_hi), .out_valid(out_valid_hi),
    .out_ready(out_ready), .acc_cnt(cnt_hi)
  );

  encoder_8to3_seq #(.PRIORITY_HIGH(0), .CNT_W(8)) u_lo (
    .clk(clk), .rst(rst), .d(d), .in_valid(in_valid), .in_ready(in_ready_lo),
    .code(code_lo), .zero(zero_lo), .multi(multi_lo), .out_valid(out_valid_lo),
    .out_ready(out_ready), .acc_cnt(cnt_lo)
  );

  encoder_8to3_seq #(.PRIORITY_HIGH(1), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .d(d), .in_valid(in_valid), .in_ready(in_ready_sat),
    .code(code_sat), .zero(zero_sat), .multi(multi_sat), .out_valid(out_valid_sat),
    .out_ready(out_ready), .acc_cnt(cnt_sat)
  );

  // ---------------- reference model ----------------
  // Highest set index = floor(log2(d)); lowest = log2 of the isolated LSB.
  function automatic int ref_code_hi(input logic [7:0] w);
    if (w == 8'h00) return 0;
    return $clog2(int'(w) + 1) - 1;
  endfunction

  function automatic int ref_code_lo(input logic [7:0] w);
    int v;
    v = int'(w);
    if (v == 0) return 0;
    return $clog2(v & -v);
  endfunction

  bit m_full;
  int m_code_hi, m_code_lo, m_zero, m_multi;
  int m_cnt;   // unbounded; each instance saturates it at its own width

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // Called with inputs already applied (just after a rising edge). Checks
  // in_ready, advances one edge, updates the model, checks the outputs.
  task automatic cycle();
    bit exp_ready;
    bit acc;
    #1;
    exp_ready = !m_full || out_ready;
    chk("in_ready_hi",  {31'd0, in_ready_hi},  {31'd0, exp_ready});
    chk("in_ready_lo",  {31'd0, in_ready_lo},  {31'd0, exp_ready});
    chk("in_ready_sat", {31'd0, in_ready_sat}, {31'd0, exp_ready});
    acc = in_valid && exp_ready;
    @(posedge clk);
    if (rst) begin
      m_full = 1'b0; m_code_hi = 0; m_code_lo = 0; m_zero = 0; m_multi = 0; m_cnt = 0;
    end else if (acc) begin
      m_full    = 1'b1;
      m_code_hi = ref_code_hi(d);
      m_code_lo = ref_code_lo(d);
      m_zero    = (d == 8'h00) ? 1 : 0;
      m_multi   = ($countones(d) > 1) ? 1 : 0;
      m_cnt     = m_cnt + 1;
    end else if (out_ready) begin
      m_full = 1'b0;
    end
    #1;
    chk("out_valid", {29'd0, out_valid_hi, out_valid_lo, out_valid_sat}, {29'd0, {3{m_full}}});
    chk("code_hi",   {29'd0, code_hi},   m_code_hi);
    chk("code_lo",   {29'd0, code_lo},   m_code_lo);
    chk("zero",      {30'd0, zero_hi, zero_lo},   {30'd0, m_zero[0], m_zero[0]});
    chk("multi",     {30'd0, multi_hi, multi_lo}, {30'd0, m_multi[0], m_multi[0]});
    chk("cnt_hi",    {24'd0, cnt_hi},  sat(m_cnt, 255));
    chk("cnt_lo",    {24'd0, cnt_lo},  sat(m_cnt, 255));
    chk("cnt_sat",   {30'd0, cnt_sat}, sat(m_cnt, 3));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [7:0] d;
    logic [2:0] code_hi;
    logic [2:0] code_lo;
    logic       zero;
    logic       multi;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{8'h01, 3'd0, 3'd0, 1'b0, 1'b0};
    vecs[1]  = '{8'h02, 3'd1, 3'd1, 1'b0, 1'b0};
    vecs[2]  = '{8'h04, 3'd2, 3'd2, 1'b0, 1'b0};
    vecs[3]  = '{8'h08, 3'd3, 3'd3, 1'b0, 1'b0};
    vecs[4]  = '{8'h10, 3'd4, 3'd4, 1'b0, 1'b0};
    vecs[5]  = '{8'h20, 3'd5, 3'd5, 1'b0, 1'b0};
    vecs[6]  = '{8'h40, 3'd6, 3'd6, 1'b0, 1'b0};
    vecs[7]  = '{8'h80, 3'd7, 3'd7, 1'b0, 1'b0};
    vecs[8]  = '{8'hA5, 3'd7, 3'd0, 1'b0, 1'b1};
    vecs[9]  = '{8'h00, 3'd0, 3'd0, 1'b1, 1'b0};
    vecs[10] = '{8'h18, 3'd4, 3'd3, 1'b0, 1'b1};
    vecs[11] = '{8'hFF, 3'd7, 3'd0, 1'b0, 1'b1};

    n_cmp = 0; n_bad = 0;
    m_full = 1'b0; m_code_hi = 0; m_code_lo = 0; m_zero = 0; m_multi = 0; m_cnt = 0;

    // Reset held for two cycles with a valid word presented.
    rst = 1'b1; in_valid = 1'b1; d = 8'h80; out_ready = 1'b1;
    @(posedge clk); #1;
    cycle();
    cycle();
    chk("rst_out_valid", {31'd0, out_valid_hi}, 32'd0);
    chk("rst_acc_cnt",   {24'd0, cnt_hi},       32'd0);
    chk("rst_in_ready",  {31'd0, in_ready_hi},  32'd1);

    // One-hot sweep then priority cases, back-to-back with out_ready=1.
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      d = vecs[i].d;
      cycle();
      chk("vec_code_hi", {29'd0, code_hi},  {29'd0, vecs[i].code_hi});
      chk("vec_code_lo", {29'd0, code_lo},  {29'd0, vecs[i].code_lo});
      chk("vec_zero",    {31'd0, zero_hi},  {31'd0, vecs[i].zero});
      chk("vec_multi",   {31'd0, multi_lo}, {31'd0, vecs[i].multi});
      chk("vec_valid",   {31'd0, out_valid_hi}, 32'd1);
      chk("vec_cnt_sat", {30'd0, cnt_sat}, (i + 1 > 3) ? 32'd3 : 32'(i + 1));
      if (i == 7) chk("sweep_cnt", {24'd0, cnt_hi}, 32'd8);
    end

    // Backpressure: hold 0x20 while 0x04 waits, then swap with no bubble.
    d = 8'h20;
    cycle();
    chk("bp_first", {29'd0, code_hi}, 32'd5);
    out_ready = 1'b0; d = 8'h04;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("bp_hold_code",  {29'd0, code_hi},     32'd5);
      chk("bp_hold_ready", {31'd0, in_ready_hi}, 32'd0);
    end
    out_ready = 1'b1;
    cycle();
    chk("bp_swap_code",  {29'd0, code_hi},      32'd2);
    chk("bp_swap_valid", {31'd0, out_valid_hi}, 32'd1);
    in_valid = 1'b0;
    cycle();
    chk("drain_valid", {31'd0, out_valid_hi}, 32'd0);
    chk("drain_code",  {29'd0, code_hi},      32'd2);
    chk("sat_hold",    {30'd0, cnt_sat},      32'd3);

    // Idle cycles change nothing.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) cycle();

    // Mid-operation reset while FULL with code 6.
    in_valid = 1'b1; d = 8'h40; out_ready = 1'b0;
    cycle();
    chk("mr_code", {29'd0, code_hi}, 32'd6);
    rst = 1'b1;
    cycle();
    chk("mr_valid", {31'd0, out_valid_hi}, 32'd0);
    chk("mr_cnt",   {24'd0, cnt_hi},       32'd0);
    rst = 1'b0; d = 8'h02; out_ready = 1'b1;
    cycle();
    chk("mr_new_code", {29'd0, code_hi}, 32'd1);
    chk("mr_new_cnt",  {24'd0, cnt_hi},  32'd1);

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      d         = 8'($urandom);
      if ($urandom_range(0, 3) == 0) d = 8'(1 << $urandom_range(0, 7));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      rst       = ($urandom_range(0, 49) == 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_encoder_8to3_seq
